// File: rtl/multicycle_controller_pkg.sv
// cpu_pkg: shared types and constants for the multi-cycle integer datapath
// controller: ALU operation codes, sequencer states and the opcodes it decodes.
package cpu_pkg;

    typedef enum logic [2:0] {
        ADD,
        SUB,
        AND,
        OR,
        XOR,
        SLL,
        SRL,
        SLT
    } alu_op_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        HALT
    } mc_state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // Base ALU operation selected by funct3; SUB is layered on top by the caller.
    function automatic alu_op_t funct3_to_op(input logic [2:0] funct3);
        alu_op_t op;
        case (funct3)
            3'b000:  op = ADD;
            3'b001:  op = SLL;
            3'b010:  op = SLT;
            3'b011:  op = SLT;
            3'b100:  op = XOR;
            3'b101:  op = SRL;
            3'b110:  op = OR;
            default: op = AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decode.sv
// alu_decode: purely combinational instruction-field decoder. Produces the ALU
// operation, immediate select and legality of an instruction word, and flags
// SYSTEM opcodes (ecall) which stop the sequencer cleanly.
module alu_decode
    import cpu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [2:0] alu_op,
    output logic       use_imm,
    output logic       legal,
    output logic       is_system
);

    // Legality and operation select; for I-type the funct7 field is imm[11:5].
    always_comb begin
        alu_op    = funct3_to_op(funct3);
        use_imm   = 1'b0;
        legal     = 1'b0;
        is_system = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct7 == FUNCT7_BASE) begin
                    legal = 1'b1;
                end else if ((funct7 == FUNCT7_ALT) && (funct3 == 3'b000)) begin
                    legal  = 1'b1;
                    alu_op = SUB;
                end
            end
            OP_I: begin
                use_imm = 1'b1;
                // Shift-right immediates only exist in the logical form here.
                legal   = (funct3 != 3'b101) || (funct7 == FUNCT7_BASE);
            end
            OP_SYSTEM: begin
                is_system = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: fetch/decode/execute/writeback sequencer for the
// integer datapath. Fetches over an imem_req/imem_ready handshake with a
// bounded wait, then issues ir_write, alu_op/use_imm, reg_write and pc_write
// in their phases. Stops for good on ecall, illegal encoding or fetch timeout.
// Build option: define MC_STEP_EN to add the step input; the sequencer then
// returns to IDLE after each writeback so one instruction retires per step.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start (or step) to begin fetching
// FETCH     | imem_req high, waiting for imem_ready, timeout running
// DECODE    | legality check of the captured instruction
// EXECUTE   | alu_op/use_imm driven from the instruction register
// WRITEBACK | reg_write (rd != 0), pc_write, retired count advances
// HALT      | terminal: ecall, illegal instruction or fetch timeout
module multicycle_controller
    import cpu_pkg::*;
#(
    parameter int COUNT_W       = 32,
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
`ifdef MC_STEP_EN
    input  logic               step,
`endif
    output logic               imem_req,
    input  logic               imem_ready,
    input  logic [31:0]        instruction,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic [2:0]         alu_op,
    output logic               use_imm,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic               fetch_fault,
    output logic [COUNT_W-1:0] retired
);

    localparam logic [2:0] S_IDLE      = IDLE;
    localparam logic [2:0] S_FETCH     = FETCH;
    localparam logic [2:0] S_DECODE    = DECODE;
    localparam logic [2:0] S_EXECUTE   = EXECUTE;
    localparam logic [2:0] S_WRITEBACK = WRITEBACK;
    localparam logic [2:0] S_HALT      = HALT;

    localparam int              TO_W    = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(FETCH_TIMEOUT - 1);

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [31:0]     ir;
    logic [TO_W-1:0] to_cnt;
    logic            go;
    logic [2:0]      wb_next;
    logic            fetch_hit;
    logic            fetch_expired;
    logic            exec_phase;

    logic [2:0]      dec_alu_op;
    logic            dec_use_imm;
    logic            dec_legal;
    logic            dec_system;

    // Register-source fields are the datapath's business, not the sequencer's.
    logic            unused_ir_fields;
    assign unused_ir_fields = ^ir[24:15];

`ifdef MC_STEP_EN
    assign go      = start | step;
    assign wb_next = S_IDLE;
`else
    assign go      = start;
    assign wb_next = S_FETCH;
`endif

    assign fetch_hit     = (state == S_FETCH) && imem_ready;
    assign fetch_expired = (state == S_FETCH) && !imem_ready && (to_cnt == '0);
    assign exec_phase    = (state == S_EXECUTE) || (state == S_WRITEBACK);

    alu_decode u_alu_decode (
        .opcode    (ir[6:0]),
        .funct3    (ir[14:12]),
        .funct7    (ir[31:25]),
        .alu_op    (dec_alu_op),
        .use_imm   (dec_use_imm),
        .legal     (dec_legal),
        .is_system (dec_system)
    );

    // Next-state selection; DECODE sends both ecall and bad encodings to HALT.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (go) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready)         state_nxt = S_DECODE;
                else if (to_cnt == '0)  state_nxt = S_HALT;
            end
            S_DECODE: begin
                state_nxt = dec_legal ? S_EXECUTE : S_HALT;
            end
            S_EXECUTE: begin
                state_nxt = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                state_nxt = wb_next;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Instruction register, written only on a completed fetch handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         ir <= '0;
        else if (fetch_hit) ir <= instruction;
    end

    // Fetch wait timer: reloaded whenever not fetching, so every FETCH entry
    // starts with the full budget; expiry is the terminal count of zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (state != S_FETCH) begin
            to_cnt <= TO_LOAD;
        end else if (!imem_ready && (to_cnt != '0)) begin
            to_cnt <= to_cnt - TO_W'(1);
        end
    end

    // Sticky halt causes; only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal     <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            if ((state == S_DECODE) && !dec_legal && !dec_system) illegal <= 1'b1;
            if (fetch_expired) fetch_fault <= 1'b1;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^COUNT_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    retired <= '0;
        else if (state == S_WRITEBACK) retired <= retired + COUNT_W'(1);
    end

    assign imem_req  = (state == S_FETCH);
    assign ir_write  = fetch_hit;
    assign pc_write  = (state == S_WRITEBACK);
    assign reg_write = (state == S_WRITEBACK) && (ir[11:7] != 5'd0);
    assign alu_op    = exec_phase ? dec_alu_op : ADD;
    assign use_imm   = exec_phase && dec_use_imm;
    assign busy      = (state == S_FETCH) || (state == S_DECODE) ||
                       (state == S_EXECUTE) || (state == S_WRITEBACK);
    assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus pushes expected
// ir_write / writeback / halt events with their cycle numbers; a monitor pops
// and compares whenever the controller presents one of those events.
module tb_multicycle_controller;

    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;
    localparam int ALU_AND = 2;
    localparam int ALU_OR  = 3;
    localparam int ALU_XOR = 4;
    localparam int ALU_SLL = 5;
    localparam int ALU_SRL = 6;
    localparam int ALU_SLT = 7;

    localparam int EV_IRW  = 1;
    localparam int EV_WB   = 2;
    localparam int EV_HALT = 3;

    localparam logic [31:0] JUNK = 32'hDEADBEEF;

`ifdef MC_STEP_EN
    localparam bit STEP_MODE = 1'b1;
`else
    localparam bit STEP_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
`ifdef MC_STEP_EN
    logic        step = 1'b0;
`endif
    logic        imem_req;
    logic        imem_ready = 1'b0;
    logic [31:0] instruction = JUNK;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [2:0]  alu_op;
    logic        use_imm;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic        fetch_fault;
    logic [31:0] retired;

    multicycle_controller #(.COUNT_W(32), .FETCH_TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
`ifdef MC_STEP_EN
        .step        (step),
`endif
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .instruction (instruction),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .alu_op      (alu_op),
        .use_imm     (use_imm),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal),
        .fetch_fault (fetch_fault),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int cyc;
        int rw;
        int op;
        int imm;
        int ret;
        int ill;
        int ff;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   base     = 0;
    int   n_ret    = 0;
    logic halted_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input int rw, input int op,
                           input int imm, input int ret, input int ill, input int ff);
        exp_t e;
        e.kind = kind; e.cyc = c; e.rw = rw; e.op = op;
        e.imm = imm; e.ret = ret; e.ill = ill; e.ff = ff;
        sb.push_back(e);
    endtask

    task automatic sb_check(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got event kind %0d at cycle %0d, expected none", kind, cyc);
            return;
        end
        e = sb.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_cycle", cyc, e.cyc);
        case (e.kind)
            EV_IRW: begin
                chk("fetch_imem_req", imem_req, 1);
                chk("fetch_alu_op", alu_op, ALU_ADD);
                chk("fetch_use_imm", use_imm, 0);
                chk("fetch_reg_write", reg_write, 0);
            end
            EV_WB: begin
                chk("wb_reg_write", reg_write, e.rw);
                chk("wb_alu_op", alu_op, e.op);
                chk("wb_use_imm", use_imm, e.imm);
                chk("wb_retired", retired, e.ret);
                chk("wb_busy", busy, 1);
            end
            default: begin
                chk("halt_illegal", illegal, e.ill);
                chk("halt_fetch_fault", fetch_fault, e.ff);
                chk("halt_imem_req", imem_req, 0);
                chk("halt_reg_write", reg_write, 0);
                chk("halt_pc_write", pc_write, 0);
                chk("halt_busy", busy, 0);
            end
        endcase
    endtask

    // Monitor: compare each presented event against the scoreboard head.
    always @(negedge clk) begin
        if (ir_write) sb_check(EV_IRW);
        if (pc_write) sb_check(EV_WB);
        if (halted && !halted_q) sb_check(EV_HALT);
        halted_q <= halted;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_imem_req"}, imem_req, 0);
        chk({tag, "_ir_write"}, ir_write, 0);
        chk({tag, "_pc_write"}, pc_write, 0);
        chk({tag, "_reg_write"}, reg_write, 0);
        chk({tag, "_alu_op"}, alu_op, 0);
        chk({tag, "_use_imm"}, use_imm, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_illegal"}, illegal, 0);
        chk({tag, "_fetch_fault"}, fetch_fault, 0);
        chk({tag, "_retired"}, retired, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
`ifdef MC_STEP_EN
        step = 1'b0;
`endif
        imem_ready  = 1'b0;
        instruction = JUNK;
        #1;
        chk_zero("rst");
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    // Cycle 0 is the IDLE cycle that samples start; FETCH begins at cycle 1.
    task automatic begin_run();
        base  = cyc;
        n_ret = 0;
        start = 1'b1;
        tick();
        if (!STEP_MODE) start = 1'b0;
    endtask

    // Called on the first FETCH cycle of an instruction; returns on the next.
    task automatic issue(input logic [31:0] ins, input int w, input bit halts,
                         input int rw, input int op, input int imm, input int ill);
        int f;
        f = cyc;
        push_ev(EV_IRW, f + w, 0, 0, 0, 0, 0, 0);
        if (halts) begin
            push_ev(EV_HALT, f + w + 2, 0, 0, 0, 0, ill, 0);
        end else begin
            push_ev(EV_WB, f + w + 3, rw, op, imm, n_ret, 0, 0);
            n_ret++;
        end
        imem_ready  = 1'b0;
        instruction = JUNK;
        repeat (w) tick();
        imem_ready  = 1'b1;
        instruction = ins;
        tick();
        imem_ready  = 1'b0;
        instruction = JUNK;
        if (halts) begin
            repeat (2) tick();
        end else begin
            repeat (3) tick();
            if (STEP_MODE) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        do_reset();

        // Mixed program: waits, rd=x0, SLT/SRL/XOR mapping, ready on last allowed cycle.
        begin_run();
        issue(32'h00500093, 0,  0, 1, ALU_ADD, 1, 0);
        issue(32'h402081B3, 3,  0, 1, ALU_SUB, 0, 0);
        issue(32'h00000033, 0,  0, 0, ALU_ADD, 0, 0);
        issue(32'h0FF06293, 1,  0, 1, ALU_OR,  1, 0);
        issue(32'h0010B313, 15, 0, 1, ALU_SLT, 1, 0);
        issue(32'h0020F3B3, 0,  0, 1, ALU_AND, 0, 0);
        issue(32'h0020D093, 2,  0, 1, ALU_SRL, 1, 0);
        issue(32'h00209233, 0,  0, 1, ALU_SLL, 0, 0);
        issue(32'hFFF0C413, 0,  0, 1, ALU_XOR, 1, 0);
        issue(32'h4010D093, 0,  1, 0, 0,       0, 1);
        imem_ready  = 1'b1;
        instruction = 32'h00500093;
        repeat (4) tick();
        imem_ready  = 1'b0;
        chk("prog_retired", retired, 9);
        chk("prog_halted_sticky", halted, 1);
        chk("prog_illegal_sticky", illegal, 1);

        // Fetch timeout: 16 FETCH cycles without ready, HALT on cycle 17.
        do_reset();
        begin_run();
        push_ev(EV_HALT, base + 17, 0, 0, 0, 0, 0, 1);
        repeat (20) tick();
        chk("timeout_retired", retired, 0);
        chk("timeout_halted", halted, 1);

        // ecall halts cleanly; other encodings halt as illegal.
        do_reset();
        begin_run();
        issue(32'h00000073, 0, 1, 0, 0, 0, 0);
        tick();
        chk("ecall_illegal", illegal, 0);
        do_reset();
        begin_run();
        issue(32'h0000007F, 0, 1, 0, 0, 0, 1);
        do_reset();
        begin_run();
        issue(32'h4020F3B3, 1, 1, 0, 0, 0, 1);

        // Asynchronous reset while in EXECUTE.
        do_reset();
        begin_run();
        issue(32'h00500093, 0, 0, 1, ALU_ADD, 1, 0);
        push_ev(EV_IRW, cyc, 0, 0, 0, 0, 0, 0);
        imem_ready  = 1'b1;
        instruction = 32'h0FF06293;
        tick();
        imem_ready  = 1'b0;
        instruction = JUNK;
        tick();
        chk("exec_alu_op", alu_op, ALU_OR);
        chk("exec_use_imm", use_imm, 1);
        chk("exec_retired", retired, 1);
        reset = 1'b0;
        start = 1'b0;
        #1;
        chk_zero("rst_exec");
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        chk("post_rst_exec_imem_req", imem_req, 0);
        chk("post_rst_exec_busy", busy, 0);

        // Reset during a fetch that has ready asserted: no capture survives.
        do_reset();
        begin_run();
        imem_ready  = 1'b1;
        instruction = 32'h00500093;
        #1;
        chk("fetch_ir_write_live", ir_write, 1);
        reset = 1'b0;
        start = 1'b0;
        #1;
        chk("rst_fetch_ir_write", ir_write, 0);
        chk("rst_fetch_imem_req", imem_req, 0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (4) tick();
        imem_ready = 1'b0;
        chk("rst_fetch_retired", retired, 0);
        chk("rst_fetch_busy", busy, 0);

`ifdef MC_STEP_EN
        // Each step pulse retires exactly one instruction, then IDLE.
        do_reset();
        base  = cyc;
        n_ret = 0;
        for (int k = 1; k <= 2; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            issue(32'h00500093, 0, 0, 1, ALU_ADD, 1, 0);
            repeat (3) tick();
            chk("step_retired", retired, k);
            chk("step_idle_busy", busy, 0);
            chk("step_idle_imem_req", imem_req, 0);
        end
`endif

        tick();
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the integer datapath (pc, instruction memory, register file, ALU, immediate mux).
- Replaces the single-cycle combinational control unit.
- Fetches each instruction over a req/ready handshake, then steps it through decode, execute and writeback.
- Emits the per-phase enables (ir_write, pc_write, reg_write) plus alu_op/use_imm, and halts on ecall, illegal instruction or fetch timeout.

Parameters:
- COUNT_W, 32, width of the retired-instruction counter.
- FETCH_TIMEOUT, 16, max cycles in FETCH without imem_ready before fault; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; leaves IDLE when high.
- imem_req  out  1  fetch request to instruction memory.
- imem_ready  in  1  instruction valid this cycle.
- instruction  in  32  fetched word, sampled when imem_req && imem_ready.
- ir_write  out  1  one-cycle pulse: datapath captures the instruction.
- pc_write  out  1  one-cycle pulse: pc <= pc+4.
- reg_write  out  1  register file write enable.
- alu_op  out  3  alu_op_t from cpu_pkg.
- use_imm  out  1  select immediate for ALU b input.
- busy  out  1  high in FETCH/DECODE/EXECUTE/WRITEBACK.
- halted  out  1  high in HALT.
- illegal  out  1  sticky: halt caused by illegal opcode/funct.
- fetch_fault  out  1  sticky: halt caused by timeout.
- retired  out  COUNT_W  count of completed writebacks.
- step  in  1  present only with MC_STEP_EN.

Behaviour:
- Reset (reset==0, async): state=IDLE; internal IR=0; all outputs 0; retired=0; timeout counter=0.
- All outputs are registered or decoded from state/IR only; no combinational path from instruction to outputs.
- IDLE: if start, go to FETCH next cycle.
- FETCH:
  - imem_req=1.
  - If imem_ready: IR<=instruction, ir_write=1 this cycle, go to DECODE.
  - Otherwise increment the timeout counter; when it reaches FETCH_TIMEOUT-1 without ready, set fetch_fault and go to HALT.
  - Counter clears on entry to FETCH.
- DECODE (1 cycle), checks IR:
  - opcode 0110011 (R-type): funct7 0000000 is legal for every funct3; funct7 0100000 is legal only for funct3 000 (SUB).
  - opcode 0010011 (I-type): funct3 010/011 are legal (SLTI/SLTIU -> SLT); funct3 101 is legal only with imm[11:5]=0000000 (no SRA).
  - opcode 1110011: go to HALT with illegal=0.
  - Anything else: illegal=1, go to HALT.
  - Legal instruction: go to EXECUTE.
- EXECUTE (1 cycle): alu_op and use_imm driven from IR (use_imm=1 for I-type); held through WRITEBACK.
- WRITEBACK (1 cycle):
  - reg_write=1 unless rd==0.
  - pc_write=1.
  - retired+=1, wrapping modulo 2^COUNT_W.
  - Go to FETCH.
- Minimum latency: 4 cycles per instruction (ready on first FETCH cycle); each wait cycle adds 1.
- HALT: absorbing. Only reset exits. imem_req=0 and all enables 0.
- ALU op mapping:
  - funct3 000 -> ADD, or SUB for R-type with funct7 0100000.
  - 001 -> SLL; 010/011 -> SLT; 100 -> XOR; 101 -> SRL; 110 -> OR; 111 -> AND.
- alu_op/use_imm are 0 (ADD, register) outside EXECUTE/WRITEBACK.
- start deasserted mid-run: ignored; only IDLE samples it.
- Reset mid-fetch: any in-flight ready is discarded; no ir_write.

Optional Feature:
- MC_STEP_EN defined: step port exists.
  - After WRITEBACK, the FSM goes to IDLE instead of FETCH.
  - From IDLE it advances on start or step, so exactly one instruction retires per step pulse.
- MC_STEP_EN undefined: no step port; WRITEBACK always goes to FETCH.

Decomposition:
- cpu_pkg holds:
  - alu_op_t enum {ADD,SUB,AND,OR,XOR,SLL,SRL,SLT};
  - opcode constants OP_R=7'b0110011, OP_I=7'b0010011, OP_SYSTEM=7'b1110011;
  - mc_state_t {IDLE,FETCH,DECODE,EXECUTE,WRITEBACK,HALT}.
- One sub-module, alu_decode: combinational funct3/funct7/opcode -> alu_op, use_imm, legal.

Test Plan:
- Reset, start=1, imem_ready always 1, instruction 0x00500093 (addi x1,x0,5):
  - ir_write on cycle 1; alu_op=ADD and use_imm=1 in EXECUTE; reg_write and pc_write in cycle 4; retired=1.
- R-type 0x402081B3 (sub x3,x1,x2), ready after 3 wait cycles:
  - ir_write on cycle 4; alu_op=SUB, use_imm=0; reg_write 3 cycles later.
- 0x00000033 (add x0,x0,x0): reg_write stays 0 in WRITEBACK, pc_write=1, retired increments.
- 0x4010D093 (srai) or 0x0000007F: HALT after DECODE; illegal=1, halted=1, no reg_write.
- imem_ready held 0 with FETCH_TIMEOUT=16: fetch_fault=1 and halted=1 after 16 FETCH cycles.
- Reset asserted in EXECUTE: all outputs 0 immediately (async), state IDLE.
- With MC_STEP_EN: one step pulse -> one retire, then IDLE.
- 0x00000073 (ecall): halted=1, illegal=0.
